// File: rtl/sa_result_collector.sv
// sa_result_collector: de-skews systolic array bottom-edge outputs into aligned vectors,
// buffers them in a credit-protected FIFO behind a valid/ready handshake.
module sa_result_collector #(
  parameter int ELEMENT_BITS = 8,
  parameter int COLS = 4,
  parameter int LAT = 3,
  parameter int DEPTH = 4
) (
  input  logic                         pe_clk,
  input  logic                         reset_n,
  input  logic                         inject,
  output logic                         inject_ready,
  input  logic [COLS*ELEMENT_BITS-1:0] col_data,
  input  logic                         flush,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [COLS*ELEMENT_BITS-1:0] res_data,
  output logic                         drop_err
);
  localparam int TL = LAT + COLS - 1;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [TL-1:0] tags;
  logic [COLS*ELEMENT_BITS-1:0] row;
  logic [COLS*ELEMENT_BITS-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] credits, fifo_cnt;
  logic acc, pop, push;
  assign inject_ready = credits < CW'(DEPTH);
  assign res_valid = fifo_cnt != '0;
  assign res_data = mem[rd_ptr];
  assign acc = inject & inject_ready;
  assign pop = res_valid & res_ready;
  assign push = tags[TL-1];
  genvar j;
  // Earlier columns are delayed so every column lines up with the last one.
  for (j = 0; j < COLS - 1; j++) begin : g_skew
    logic [ELEMENT_BITS-1:0] sr [COLS-1-j];
    always_ff @(posedge pe_clk) begin
      sr[0] <= col_data[j*ELEMENT_BITS +: ELEMENT_BITS];
      for (int k = 1; k < COLS - 1 - j; k++) sr[k] <= sr[k-1];
    end
    assign row[j*ELEMENT_BITS +: ELEMENT_BITS] = sr[COLS-2-j];
  end
  assign row[(COLS-1)*ELEMENT_BITS +: ELEMENT_BITS] = col_data[(COLS-1)*ELEMENT_BITS +: ELEMENT_BITS];
  always_ff @(posedge pe_clk) begin
    if (!reset_n) begin
      tags <= '0;
      credits <= '0;
      fifo_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      tags <= '0;
      credits <= '0;
      fifo_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      tags <= {tags[TL-2:0], acc};
      credits <= credits + CW'(acc) - CW'(pop);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (push) begin
        mem[wr_ptr] <= row;
        wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + AW'(1);
      if (inject && !inject_ready) drop_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sa_result_collector.sv
// tb_sa_result_collector: directed and random stimulus against a queue-based
// model of result order, latency and credits.
module tb_sa_result_collector;
  logic pe_clk = 1'b0;
  logic reset_n = 1'b0;
  logic inject = 1'b0;
  logic inject_ready;
  logic [31:0] col_data = '0;
  logic flush = 1'b0;
  logic res_valid;
  logic res_ready = 1'b0;
  logic [31:0] res_data;
  logic drop_err;
  typedef struct {logic [31:0] d; int rdy;} ent_t;
  ent_t q[$];
  logic [31:0] inj_vec [int];
  int n = 0;
  int m_cred = 0;
  bit m_drop = 1'b0;
  int tests = 0;
  int fails = 0;
  sa_result_collector dut (
    .pe_clk(pe_clk), .reset_n(reset_n), .inject(inject), .inject_ready(inject_ready),
    .col_data(col_data), .flush(flush), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .drop_err(drop_err)
  );
  always #5 pe_clk = ~pe_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask
  task automatic check_all();
    bit ev;
    ev = q.size() > 0 && q[0].rdy <= n;
    chk("res_valid", 32'(res_valid), 32'(ev));
    chk("inject_ready", 32'(inject_ready), 32'(m_cred < 4));
    chk("drop_err", 32'(drop_err), 32'(m_drop));
    if (ev) chk("res_data", res_data, q[0].d);
  endtask
  task automatic step(input bit inj, input bit rdy, input bit fl, input bit rstn, input logic [31:0] v);
    bit acc, pop;
    logic [31:0] t;
    @(negedge pe_clk);
    inject = inj;
    res_ready = rdy;
    flush = fl;
    reset_n = rstn;
    if (inj) inj_vec[n] = v;
    for (int j = 0; j < 4; j++) begin
      t = inj_vec.exists(n - 3 - j) ? inj_vec[n - 3 - j] : $urandom;
      col_data[j*8 +: 8] = t[j*8 +: 8];
    end
    pop = q.size() > 0 && q[0].rdy <= n && rdy;
    acc = inj && m_cred < 4;
    if (!rstn) begin
      q.delete();
      m_cred = 0;
      m_drop = 1'b0;
    end else if (fl) begin
      q.delete();
      m_cred = 0;
    end else begin
      if (inj && !acc) m_drop = 1'b1;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{d: v, rdy: n + 7});
      m_cred += int'(acc) - int'(pop);
    end
    @(posedge pe_clk);
    #1;
    n++;
    check_all();
  endtask
  initial begin
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("reset_res_data", res_data, 32'h0);
    step(1, 1, 0, 1, 32'h13121110);
    repeat (10) step(0, 1, 0, 1, 0);
    repeat (6) step(1, 0, 0, 1, $urandom);
    repeat (8) step(0, 0, 0, 1, 0);
    repeat (8) step(0, 1, 0, 1, 0);
    step(1, 0, 0, 1, $urandom);
    step(1, 0, 0, 1, $urandom);
    repeat (9) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("midrst_res_data", res_data, 32'h0);
    step(1, 0, 0, 1, 32'hAAAA_5555);
    step(1, 0, 0, 1, 32'hBBBB_6666);
    repeat (17) step(0, 0, 0, 1, 0);
    repeat (5) step(0, 1, 0, 1, 0);
    repeat (20) step(1, 1, 0, 1, $urandom);
    repeat (10) step(0, 1, 0, 1, 0);
    repeat (3) step(1, 1, 0, 1, $urandom);
    step(0, 1, 0, 1, 0);
    step(1, 1, 1, 1, $urandom);
    step(0, 1, 0, 1, 0);
    step(1, 1, 0, 1, $urandom);
    repeat (10) step(0, 1, 0, 1, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(9) < 7, $urandom_range(9) < 6, $urandom_range(99) < 3,
           $urandom_range(99) != 0, $urandom);
    repeat (12) step(0, 1, 0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
